// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - sigma constants, FSM encoding and quarter-round index table
package chacha_pkg;

  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FIN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // One row per quarter-round of a double round (four columns, then four diagonals); one nibble per word index.
  localparam logic [0:7][0:3][3:0] QR_TABLE = {
    16'h048c, 16'h159d, 16'h26ae, 16'h37bf,
    16'h05af, 16'h16bc, 16'h278d, 16'h349e
  };

endpackage

// File: rtl/chacha_qr.sv
// rtl/chacha_qr.sv - combinational ChaCha quarter-round on four 32-bit words
module chacha_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  logic [31:0] a1, b1, c1, d1;

  assign a1    = a + b;
  assign d1    = rotl(d ^ a1, 16);
  assign c1    = c + d1;
  assign b1    = rotl(b ^ c1, 12);
  assign a_new = a1 + b1;
  assign d_new = rotl(d1 ^ a_new, 8);
  assign c_new = c1 + d_new;
  assign b_new = rotl(b1 ^ c_new, 7);

endmodule

// File: rtl/chacha_block_stream.sv
// rtl/chacha_block_stream.sv - multi-block ChaCha keystream generator with double-buffered output
module chacha_block_stream
  import chacha_pkg::*;
#(
  parameter int DOUBLE_ROUNDS = 10,
  parameter int QR_PER_CYCLE  = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [255:0] key_i,
  input  logic [95:0]  nonce_i,
  input  logic [31:0]  counter_i,
  input  logic [15:0]  nblocks_i,
  input  logic         start_i,
  input  logic         abort_i,
  output logic         ready_o,
  output logic [511:0] ks_data_o,
  output logic [31:0]  ks_counter_o,
  output logic         ks_last_o,
  output logic         ks_valid_o,
  input  logic         ks_ready_i,
  output logic         done_o,
  output logic         overflow_o
);

  localparam int STEPS = 8 / QR_PER_CYCLE;

  state_t state, state_next;

  logic [255:0]      key_q;
  logic [95:0]       nonce_q;
  logic [31:0]       ctr_q;
  logic [15:0]       left_q;
  logic [2:0]        step_q;
  logic [7:0]        dr_q;
  logic [15:0][31:0] init_q, work_q, init_w, round_w, sum_w;

  logic [QR_PER_CYCLE-1:0][2:0]       sel;
  logic [QR_PER_CYCLE-1:0][3:0][31:0] qr_out;

  logic start_ok, kill, fin_write, last_blk, slot_free, rounds_end;

  assign init_w = {nonce_q, ctr_q, key_q, SIGMA};

  for (genvar q = 0; q < QR_PER_CYCLE; q++) begin : g_qr
    assign sel[q] = 3'(int'(step_q) * QR_PER_CYCLE + q);
    chacha_qr u_qr (
      .a    (work_q[QR_TABLE[sel[q]][0]]),
      .b    (work_q[QR_TABLE[sel[q]][1]]),
      .c    (work_q[QR_TABLE[sel[q]][2]]),
      .d    (work_q[QR_TABLE[sel[q]][3]]),
      .a_new(qr_out[q][0]),
      .b_new(qr_out[q][1]),
      .c_new(qr_out[q][2]),
      .d_new(qr_out[q][3])
    );
  end

  // Quarter-rounds sharing a cycle touch disjoint words, so their writes never collide.
  always_comb begin
    round_w = work_q;
    for (int q = 0; q < QR_PER_CYCLE; q++) begin
      for (int k = 0; k < 4; k++) begin
        round_w[QR_TABLE[sel[q]][k]] = qr_out[q][k];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sum_w[i] = work_q[i] + init_q[i];
    end
  end

  assign kill       = abort_i && (state != ST_IDLE);
  assign start_ok   = (state == ST_IDLE) && start_i && (nblocks_i != 16'd0) && !abort_i;
  assign slot_free  = !ks_valid_o || ks_ready_i;
  assign last_blk   = (left_q == 16'd1) || (ctr_q == 32'hffff_ffff);
  assign rounds_end = (step_q == 3'(STEPS - 1)) && (dr_q == 8'(DOUBLE_ROUNDS - 1));
  assign ready_o    = (state == ST_IDLE);
  assign done_o     = (state == ST_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fin_write  = 1'b0;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_ROUND;
      ST_ROUND: if (rounds_end) state_next = ST_FIN;
      ST_FIN: begin
        if (slot_free) begin
          fin_write  = 1'b1;
          state_next = last_blk ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_DRAIN: if (ks_valid_o && ks_ready_i) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (kill) begin
      state_next = ST_IDLE;
      fin_write  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_q        <= '0;
      nonce_q      <= '0;
      ctr_q        <= '0;
      left_q       <= '0;
      step_q       <= '0;
      dr_q         <= '0;
      init_q       <= '0;
      work_q       <= '0;
      ks_data_o    <= '0;
      ks_counter_o <= '0;
      ks_last_o    <= 1'b0;
      ks_valid_o   <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (start_ok) begin
        key_q      <= key_i;
        nonce_q    <= nonce_i;
        ctr_q      <= counter_i;
        left_q     <= nblocks_i;
        overflow_o <= 1'b0;
      end
      if (state == ST_LOAD) begin
        init_q <= init_w;
        work_q <= init_w;
        step_q <= '0;
        dr_q   <= '0;
      end
      if (state == ST_ROUND) begin
        work_q <= round_w;
        if (step_q == 3'(STEPS - 1)) begin
          step_q <= '0;
          dr_q   <= dr_q + 8'd1;
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
      if (kill) begin
        ks_valid_o <= 1'b0;
        ks_last_o  <= 1'b0;
      end else if (fin_write) begin
        ks_data_o    <= sum_w;
        ks_counter_o <= ctr_q;
        ks_valid_o   <= 1'b1;
        ks_last_o    <= last_blk;
        ctr_q        <= ctr_q + 32'd1;
        left_q       <= left_q - 16'd1;
        if (ctr_q == 32'hffff_ffff && left_q != 16'd1) overflow_o <= 1'b1;
      end else if (ks_valid_o && ks_ready_i) begin
        ks_valid_o <= 1'b0;
        ks_last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chacha_block_stream.sv
// tb/tb_chacha_block_stream.sv - directed vector bench for chacha_block_stream
module tb_chacha_block_stream;

  logic clk, rst, start, abort, ks_ready, multi;
  logic [255:0] key, key_ref;
  logic [95:0] nonce, nonce_ref;
  logic [31:0] counter;
  logic [15:0] nblocks;
  logic start_par;

  logic ready, ks_last, ks_valid, done, overflow;
  logic [511:0] ks_data;
  logic [31:0] ks_counter;
  logic ready2, last2, valid2, done2, ovf2;
  logic [511:0] data2;
  logic [31:0] ctr2;
  logic ready4, last4, valid4, done4, ovf4;
  logic [511:0] data4;
  logic [31:0] ctr4;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] ctr;
    logic [15:0] nb;
    logic [7:0]  exp_blocks;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [4];

  assign start_par = start & multi;

  chacha_block_stream #(.DOUBLE_ROUNDS(10), .QR_PER_CYCLE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .key_i(key), .nonce_i(nonce), .counter_i(counter),
    .nblocks_i(nblocks), .start_i(start), .abort_i(abort), .ready_o(ready),
    .ks_data_o(ks_data), .ks_counter_o(ks_counter), .ks_last_o(ks_last),
    .ks_valid_o(ks_valid), .ks_ready_i(ks_ready), .done_o(done), .overflow_o(overflow));

  chacha_block_stream #(.DOUBLE_ROUNDS(10), .QR_PER_CYCLE(2)) u2 (
    .clk_i(clk), .rst_i(rst), .key_i(key), .nonce_i(nonce), .counter_i(counter),
    .nblocks_i(nblocks), .start_i(start_par), .abort_i(abort), .ready_o(ready2),
    .ks_data_o(data2), .ks_counter_o(ctr2), .ks_last_o(last2),
    .ks_valid_o(valid2), .ks_ready_i(ks_ready), .done_o(done2), .overflow_o(ovf2));

  chacha_block_stream #(.DOUBLE_ROUNDS(10), .QR_PER_CYCLE(4)) u4 (
    .clk_i(clk), .rst_i(rst), .key_i(key), .nonce_i(nonce), .counter_i(counter),
    .nblocks_i(nblocks), .start_i(start_par), .abort_i(abort), .ready_o(ready4),
    .ks_data_o(data4), .ks_counter_o(ctr4), .ks_last_o(last4),
    .ks_valid_o(valid4), .ks_ready_i(ks_ready), .done_o(done4), .overflow_o(ovf4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_qr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  function automatic logic [511:0] ref_block(input logic [31:0] ctr);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [127:0] t;
    logic [511:0] res;
    int a, b, c, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = key_ref[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = nonce_ref[32*i +: 32];
    x = s;
    for (int rnd = 0; rnd < 10; rnd++) begin
      for (int j = 0; j < 8; j++) begin
        a = j % 4;
        if (j < 4) begin
          b = a + 4; c = a + 8; d = a + 12;
        end else begin
          b = 4 + (a + 1) % 4; c = 8 + (a + 2) % 4; d = 12 + (a + 3) % 4;
        end
        t = ref_qr(x[a], x[b], x[c], x[d]);
        x[a] = t[31:0]; x[b] = t[63:32]; x[c] = t[95:64]; x[d] = t[127:96];
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
    return res;
  endfunction

  // Inputs are scrambled right after the start edge so latching is exercised on every run.
  task automatic start_run(input logic [31:0] c, input logic [15:0] nb);
    @(negedge clk);
    key = key_ref; nonce = nonce_ref; counter = c; nblocks = nb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; key = ~key_ref; nonce = ~nonce_ref; counter = 32'h1234_5678; nblocks = 16'hffff;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int got, n, prev;
    logic [31:0] c;
    start_run(v.ctr, v.nb);
    check($sformatf("v%0d ovf clear on start", idx), overflow, 1'b0);
    got = 0; n = 0; prev = 0; c = v.ctr;
    while (got < int'(v.exp_blocks) && n < 1000) begin
      if (ks_valid) begin
        check($sformatf("v%0d ctr", idx), ks_counter, c);
        check($sformatf("v%0d data", idx), ks_data, ref_block(c));
        check($sformatf("v%0d last", idx), ks_last, got == int'(v.exp_blocks) - 1);
        check($sformatf("v%0d spacing", idx), n - prev, 82);
        prev = n; got++; c++;
      end
      @(negedge clk); n++;
    end
    check($sformatf("v%0d blocks", idx), got, v.exp_blocks);
    check($sformatf("v%0d done pulse", idx), done, 1'b1);
    check($sformatf("v%0d no extra block", idx), ks_valid, 1'b0);
    @(negedge clk);
    check($sformatf("v%0d done low", idx), done, 1'b0);
    check($sformatf("v%0d ready", idx), ready, 1'b1);
    check($sformatf("v%0d overflow", idx), overflow, v.exp_ovf);
  endtask

  initial begin
    int lat1, lat2, lat4, n, cnt, bad;
    logic [511:0] d1, d2, d4, hold;
    logic [31:0] lastc;
    logic l1;

    for (int i = 0; i < 32; i++) key_ref[8*i +: 8] = 8'(i);
    nonce_ref = {32'h00000000, 32'h4a000000, 32'h09000000};
    vecs[0] = '{32'd1,         16'd1, 8'd1, 1'b0};
    vecs[1] = '{32'd0,         16'd2, 8'd2, 1'b0};
    vecs[2] = '{32'hffff_ffff, 16'd1, 8'd1, 1'b0};
    vecs[3] = '{32'hffff_fffe, 16'd5, 8'd2, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ks_ready = 1'b1; multi = 1'b0;
    key = key_ref; nonce = nonce_ref; counter = '0; nblocks = '0;
    repeat (2) @(negedge clk);
    check("rst ready", ready, 1'b1);
    check("rst valid", ks_valid, 1'b0);
    check("rst last", ks_last, 1'b0);
    check("rst done", done, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst data", ks_data, 512'd0);
    check("rst counter", ks_counter, 32'd0);
    rst = 1'b0;

    // RFC 8439 block at all three parallelism settings
    multi = 1'b1;
    start_run(32'd1, 16'd1);
    multi = 1'b0;
    lat1 = -1; lat2 = -1; lat4 = -1; d1 = '0; d2 = '0; d4 = '0; l1 = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (ks_valid && lat1 < 0) begin lat1 = i; d1 = ks_data; l1 = ks_last; end
      if (valid2 && lat2 < 0) begin lat2 = i; d2 = data2; end
      if (valid4 && lat4 < 0) begin lat4 = i; d4 = data4; end
      @(negedge clk);
    end
    check("rfc lat qr1", lat1, 82);
    check("rfc lat qr2", lat2, 42);
    check("rfc lat qr4", lat4, 22);
    check("rfc w0", d1[31:0], 32'he4e7f110);
    check("rfc w15", d1[511:480], 32'h4e3c50a2);
    check("rfc last", l1, 1'b1);
    check("rfc full", d1, ref_block(32'd1));
    check("rfc qr2 data", d2, d1);
    check("rfc qr4 data", d4, d1);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // overflow is sticky, and a zero-length start is not accepted
    repeat (20) @(negedge clk);
    check("ovf sticky", overflow, 1'b1);
    nblocks = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!ready || ks_valid || done) bad++;
      @(negedge clk);
    end
    check("nb0 ignored", bad, 0);
    check("nb0 keeps ovf", overflow, 1'b1);

    // start while busy has no effect
    ks_ready = 1'b1;
    start_run(32'd1, 16'd1);
    repeat (10) @(negedge clk);
    counter = 32'h55; nblocks = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt = 0; lastc = '0;
    for (int i = 0; i < 300; i++) begin
      if (ks_valid) begin cnt++; lastc = ks_counter; end
      @(negedge clk);
    end
    check("busy start blocks", cnt, 1);
    check("busy start ctr", lastc, 32'd1);
    check("busy start idle", ready, 1'b1);

    // back-pressure: block 7 held, block 8 parked in FIN
    ks_ready = 1'b0;
    start_run(32'd7, 16'd3);
    n = 0;
    while (!ks_valid && n < 300) begin @(negedge clk); n++; end
    check("bp ctr7", ks_counter, 32'd7);
    check("bp last7", ks_last, 1'b0);
    check("bp data7", ks_data, ref_block(32'd7));
    hold = ks_data; bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (ks_data !== hold || !ks_valid || ks_counter !== 32'd7 || ks_last) bad++;
    end
    check("bp stable", bad, 0);
    ks_ready = 1'b1;
    @(negedge clk);
    check("bp ctr8 immediate", ks_counter, 32'd8);
    check("bp valid8", ks_valid, 1'b1);
    check("bp data8", ks_data, ref_block(32'd8));
    check("bp last8", ks_last, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(ks_valid && ks_counter == 32'd9) && n < 300);
    check("bp ctr9", ks_counter, 32'd9);
    check("bp last9", ks_last, 1'b1);
    check("bp data9", ks_data, ref_block(32'd9));
    @(negedge clk);
    check("bp done", done, 1'b1);

    // abort during ROUND of block 2 while block 1 is held
    @(negedge clk);
    ks_ready = 1'b0;
    start_run(32'd1, 16'd4);
    n = 0;
    while (!ks_valid && n < 300) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort valid", ks_valid, 1'b0);
    check("abort last", ks_last, 1'b0);
    check("abort ready", ready, 1'b1);
    check("abort ovf", overflow, 1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (done || ks_valid) bad++;
      @(negedge clk);
    end
    check("abort quiet", bad, 0);
    ks_ready = 1'b1;
    run_vec(4, vecs[0]);

    // async reset between edges with block 2 waiting in FIN
    ks_ready = 1'b0;
    start_run(32'd3, 16'd2);
    n = 0;
    while (!ks_valid && n < 300) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst valid", ks_valid, 1'b0);
    check("arst ready", ready, 1'b1);
    check("arst data", ks_data, 512'd0);
    check("arst counter", ks_counter, 32'd0);
    check("arst last", ks_last, 1'b0);
    check("arst done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0; ks_ready = 1'b1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || ks_valid || !ready) bad++;
      @(negedge clk);
    end
    check("arst quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
